// File: rtl/soc_riscv_pkg.sv
// Shared types for the RISC-V load/store path: access sizes, LSU states, data width.
package soc_riscv_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/soc_riscv_lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module soc_riscv_lsu_align
  import soc_riscv_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  mem_size_t         size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = word[{offset, 3'b000} +: 8];
    lane_h     = word[{offset[1], 4'b0000} +: 16];
    load_data  = word;
    store_word = wdata;
    case (size)
      BYTE: begin
        load_data  = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
        store_word = word;
        store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      HALF: begin
        load_data  = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
        store_word = word;
        store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/soc_riscv_lsu_axil.sv
// AXI-lite data-port initiator: one core load/store becomes AR/R or AW/W traffic,
// with read-modify-write for sub-word stores and early rejection of misaligned requests.
module soc_riscv_lsu_axil #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY
);
  import soc_riscv_pkg::*;

  lsu_state_t        state, state_d;
  logic              r_we, r_unsigned;
  logic [1:0]        r_size, r_off;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] load_data, merged;
  logic              aw_done, w_done;
  logic              aw_hs, w_hs, misaligned, accept, enter_wr;

  assign aw_hs    = AWVALID & AWREADY;
  assign w_hs     = WVALID & WREADY;
  assign accept   = (state == IDLE) & req_valid;
  assign enter_wr = (state != WR) & (state_d == WR);

  always_comb begin
    misaligned = 1'b0;
    case (mem_size_t'(req_size))
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = req_addr[0];
      WORD:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  soc_riscv_lsu_align u_align (
    .word        (RDATA),
    .offset      (r_off),
    .size        (mem_size_t'(r_size)),
    .is_unsigned (r_unsigned),
    .wdata       (r_wdata),
    .load_data   (load_data),
    .store_word  (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (req_valid) begin
        if (misaligned)                                state_d = RESP;
        else if (!req_we || req_size != 2'(WORD))      state_d = RD_A;
        else                                           state_d = WR;
      end
      RD_A:    if (ARREADY) state_d = RD_D;
      RD_D:    if (RVALID)  state_d = r_we ? WR : RESP;
      WR:      if ((aw_done | aw_hs) & (w_done | w_hs)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every bus/core output is a flop loaded from the next state, so VALIDs never
  // combinationally follow READY and all outputs clear with the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      ARADDR     <= '0;
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
      AWADDR     <= '0;
      AWVALID    <= 1'b0;
      WDATA      <= '0;
      WVALID     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
    end else begin
      req_ready <= (state_d == IDLE);
      ARVALID   <= (state_d == RD_A);
      RREADY    <= (state_d == RD_D);
      rsp_valid <= (state_d == RESP);
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (accept) begin
        r_we       <= req_we;
        r_unsigned <= req_unsigned;
        r_size     <= req_size;
        r_off      <= req_addr[1:0];
        r_wdata    <= req_wdata;
        rsp_err    <= misaligned;
        ARADDR     <= {req_addr[ADDR_W-1:2], 2'b00};
        AWADDR     <= {req_addr[ADDR_W-1:2], 2'b00};
        WDATA      <= req_wdata;
      end
      if (state == RD_D && RVALID) begin
        if (r_we) WDATA     <= merged;
        else      rsp_rdata <= load_data;
      end
      if (enter_wr) begin
        AWVALID <= 1'b1;
        WVALID  <= 1'b1;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) begin
          AWVALID <= 1'b0;
          aw_done <= 1'b1;
        end
        if (w_hs) begin
          WVALID <= 1'b0;
          w_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_riscv_lsu_axil.sv
// Bench for soc_riscv_lsu_axil: AXI-lite RAM responder with programmable wait states
// and a word-array reference model of loads, stores and latency.
module tb_soc_riscv_lsu_axil;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic        ARVALID, RREADY, AWVALID, WVALID;
  logic        ARREADY = 1'b0, RVALID = 1'b0, AWREADY = 1'b0, WREADY = 1'b0;
  logic [31:0] RDATA = '0;

  soc_riscv_lsu_axil #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_fail = 0;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] ram [16];

  // Bus monitor: handshake capture for the responder, counters, stability rules.
  logic        hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0;
  logic [31:0] hs_ar_addr = '0, hs_aw_addr = '0, hs_w_data = '0;
  logic        pv_ar = 0, pv_aw = 0, pv_w = 0;
  logic [31:0] pa_ar = '0, pa_aw = '0, pd_w = '0;
  int proto_viol = 0, rsp_cnt = 0, ar_cnt_hs = 0, aw_cnt_hs = 0, w_cnt_hs = 0, valid_cyc = 0;
  logic [31:0] last_araddr = '0, last_wdata = '0;

  always @(posedge clk) begin
    if (!rst) begin
      hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0;
      pv_ar = 0; pv_aw = 0; pv_w = 0;
    end else begin
      if (pv_ar && !hs_ar && (!ARVALID || ARADDR !== pa_ar)) proto_viol++;
      if (pv_aw && !hs_aw && (!AWVALID || AWADDR !== pa_aw)) proto_viol++;
      if (pv_w && !hs_w && (!WVALID || WDATA !== pd_w)) proto_viol++;
      if ((hs_ar && ARVALID) || (hs_aw && AWVALID) || (hs_w && WVALID)) proto_viol++;
      hs_ar = ARVALID && ARREADY;  hs_ar_addr = ARADDR;
      hs_r  = RVALID && RREADY;
      hs_aw = AWVALID && AWREADY;  hs_aw_addr = AWADDR;
      hs_w  = WVALID && WREADY;    hs_w_data = WDATA;
      pv_ar = ARVALID; pa_ar = ARADDR;
      pv_aw = AWVALID; pa_aw = AWADDR;
      pv_w  = WVALID;  pd_w  = WDATA;
      if (hs_ar) begin ar_cnt_hs++; last_araddr = ARADDR; end
      if (hs_aw) aw_cnt_hs++;
      if (hs_w) begin w_cnt_hs++; last_wdata = WDATA; end
      if (rsp_valid) rsp_cnt++;
      if (ARVALID || AWVALID || WVALID) valid_cyc++;
    end
  end

  // RAM responder, driving its outputs on the falling edge.
  int ac = 0, rc = 0, awc = 0, wc = 0;
  logic rd_pend = 0, aw_got = 0, w_got = 0;
  logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; RDATA = '0;
      rd_pend = 0; aw_got = 0; w_got = 0; ac = 0; rc = 0; awc = 0; wc = 0;
    end else begin
      if (hs_ar) begin ARREADY = 0; rd_addr = hs_ar_addr; rd_pend = 1; rc = 0; ac = 0; end
      else if (ARVALID && !ARREADY) begin if (ac >= ar_wait) ARREADY = 1; else ac++; end
      if (hs_r) begin RVALID = 0; rd_pend = 0; end
      else if (rd_pend && !RVALID) begin
        if (rc >= r_wait) begin RVALID = 1; RDATA = ram[rd_addr[5:2]]; end else rc++;
      end
      if (hs_aw) begin AWREADY = 0; aw_got = 1; wr_addr = hs_aw_addr; awc = 0; end
      else if (AWVALID && !AWREADY && !aw_got) begin if (awc >= aw_wait) AWREADY = 1; else awc++; end
      if (hs_w) begin WREADY = 0; w_got = 1; wr_data = hs_w_data; wc = 0; end
      else if (WVALID && !WREADY && !w_got) begin if (wc >= w_wait) WREADY = 1; else wc++; end
      if (aw_got && w_got) begin ram[wr_addr[5:2]] = wr_data; aw_got = 0; w_got = 0; end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
    return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
    logic [31:0] v;
    if (size == 0) begin
      v = (w >> (8 * (addr % 4))) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (w >> (16 * ((addr % 4) / 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] wd);
    int unsigned sh;
    logic [31:0] m;
    if (size == 0) begin
      sh = 8 * (addr % 4); m = 32'hFF << sh;
      return (w & ~m) | ((wd & 32'hFF) << sh);
    end else if (size == 1) begin
      sh = 16 * ((addr % 4) / 2); m = 32'hFFFF << sh;
      return (w & ~m) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 0;
    check("busy_ready", req_ready, 0);
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    rdata = rsp_rdata; err = rsp_err;
    @(posedge clk); #1;
    check("rsp_pulse", rsp_valid, 0);
    check("ready_after", req_ready, 1);
  endtask

  logic [31:0] last_rd;
  logic        last_err;

  task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_rd, got_rd;
    logic        exp_err, got_err;
    int          exp_lat, got_lat, idx, wmax;
    idx  = (addr / 4) % 16;
    wmax = (aw_wait > w_wait) ? aw_wait : w_wait;
    exp_err = is_mis(size, addr);
    exp_rd  = 0;
    if (exp_err) exp_lat = 1;
    else if (!we) begin
      exp_rd  = model_load(ref_mem[idx], size, uns, addr);
      exp_lat = 3 + ar_wait + r_wait;
    end else begin
      ref_mem[idx] = model_store(ref_mem[idx], size, addr, wdata);
      exp_lat = (size == 2) ? 2 + wmax : 4 + ar_wait + r_wait + wmax;
    end
    do_req(we, size, uns, addr, wdata, got_rd, got_err, got_lat);
    check({tag, ".rdata"}, got_rd, exp_rd);
    check({tag, ".err"}, 32'(got_err), 32'(exp_err));
    check({tag, ".lat"}, got_lat, exp_lat);
    last_rd = got_rd; last_err = got_err;
  endtask

  initial begin
    int c0, c1, c2, c3;
    logic [31:0] a;
    logic [1:0]  sz;

    repeat (3) @(posedge clk);
    #1;
    check("rst.req_ready", req_ready, 0);
    check("rst.valids", {ARVALID, RREADY, AWVALID, WVALID, rsp_valid, rsp_err}, 0);
    check("rst.araddr", ARADDR, 0);
    check("rst.awaddr", AWADDR, 0);
    check("rst.wdata", WDATA, 0);
    check("rst.rdata", rsp_rdata, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    check("rst.ready_release", req_ready, 1);

    for (int i = 0; i < 16; i++) txn("init", 1, 2, 0, 32'(i * 4), $urandom);

    txn("st_w", 1, 2, 0, 32'h10, 32'hDEAD_BEEF);
    txn("ld_w", 0, 2, 0, 32'h10, $urandom);
    check("ld_w.const", last_rd, 32'hDEAD_BEEF);
    check("ld_w.araddr", last_araddr, 32'h10);

    txn("st_lb", 1, 2, 0, 32'h10, 32'h80FF_7F01);
    txn("lb_s13", 0, 0, 0, 32'h13, 0);
    check("lb_s13.const", last_rd, 32'hFFFF_FF80);
    check("lb_s13.araddr", last_araddr, 32'h10);
    txn("lb_u13", 0, 0, 1, 32'h13, 0);
    check("lb_u13.const", last_rd, 32'h0000_0080);
    txn("lb_s11", 0, 0, 0, 32'h11, 0);
    check("lb_s11.const", last_rd, 32'h0000_007F);

    txn("st_sh", 1, 2, 0, 32'h20, 32'h1122_3344);
    c0 = ar_cnt_hs;
    txn("sh_rmw", 1, 1, 0, 32'h22, 32'h5555_ABCD);
    check("sh_rmw.ar_count", ar_cnt_hs - c0, 1);
    check("sh_rmw.wdata", last_wdata, 32'hABCD_3344);
    txn("sh_back", 0, 2, 0, 32'h20, 0);
    check("sh_back.const", last_rd, 32'hABCD_3344);

    for (int k = 0; k < 2; k++) begin
      aw_wait = (k == 0) ? 0 : 3;
      w_wait  = (k == 0) ? 3 : 0;
      c0 = aw_cnt_hs; c1 = w_cnt_hs; c2 = rsp_cnt;
      txn(k == 0 ? "wlate" : "awlate", 1, 2, 0, 32'h30, 32'h5A5A_1230 + 32'(k));
      check("order.aw_count", aw_cnt_hs - c0, 1);
      check("order.w_count", w_cnt_hs - c1, 1);
      check("order.rsp_count", rsp_cnt - c2, 1);
      check("order.wdata", last_wdata, 32'h5A5A_1230 + 32'(k));
    end
    aw_wait = 0; w_wait = 0;

    c0 = valid_cyc;
    txn("mis_lw06", 0, 2, 0, 32'h06, 0);
    check("mis_lw06.err_const", 32'(last_err), 1);
    txn("mis_sh03", 1, 1, 0, 32'h03, 32'h1234_5678);
    txn("mis_sz3", 0, 3, 0, 32'h08, 0);
    check("mis.no_channel", valid_cyc - c0, 0);

    r_wait = 1000;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2; req_unsigned = 0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 0;
    c1 = 0;
    while (!RREADY && c1 < 20) begin @(posedge clk); #1; c1++; end
    check("midrst.in_rd_d", RREADY, 1);
    @(posedge clk); #3;
    c2 = rsp_cnt;
    rst = 0; #1;
    check("midrst.valids", {ARVALID, RREADY, AWVALID, WVALID, rsp_valid}, 0);
    check("midrst.req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    r_wait = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    check("midrst.ready_release", req_ready, 1);
    check("midrst.no_rsp", rsp_cnt - c2, 0);
    txn("midrst.ld", 0, 2, 0, 32'h10, 0);

    for (int i = 0; i < 40; i++) begin
      ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 63);
      if ($urandom_range(0, 2) != 0) a = a & ~32'h3;
      c3 = $urandom_range(0, 1);
      txn("rand", c3[0], sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    for (int i = 0; i < 16; i++) check("ram_final", ram[i], ref_mem[i]);
    check("protocol_violations", proto_viol, 0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
